// File: rtl/cnn_sdiv_seq_22s_9s.sv
// -----------------------------------------------------------------------------
// cnn_sdiv_seq_22s_9s
// Sequential signed divider built on a restoring radix-2 magnitude core. It
// produces a saturated signed quotient and a remainder that carries the sign
// of the dividend.
//
// Ports
//   ap_clk    in   clock, rising edge
//   ap_rst_n  in   asynchronous active-low reset
//   ap_start  in   start request, sampled only while idle
//   din0      in   signed dividend  [DIVIDEND_W]
//   din1      in   signed divisor   [DIVISOR_W]
//   ap_idle   out  high while a request can be accepted
//   ap_done   out  one-cycle pulse, results valid
//   dout      out  signed quotient (saturated) [QUOT_W]
//   rem       out  signed remainder [DIVISOR_W]
//   ovf       out  quotient saturated
//   dbz       out  divisor was zero
//
// Timing: accept edge -> DIVIDEND_W CALC cycles -> FIX -> DONE (ap_done=1).
// -----------------------------------------------------------------------------
module cnn_sdiv_seq_22s_9s #(
    parameter logic [31:0] ID         = 32'd1,
    parameter int          DIVIDEND_W = 22,
    parameter int          DIVISOR_W  = 9,
    parameter int          QUOT_W     = 14
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    input  logic signed [DIVIDEND_W-1:0] din0,
    input  logic signed [DIVISOR_W-1:0]  din1,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic signed [QUOT_W-1:0]     dout,
    output logic signed [DIVISOR_W-1:0]  rem,
    output logic                         ovf,
    output logic                         dbz
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - 1);

    // Magnitude limits for the positive and negative saturation checks.
    localparam logic [DIVIDEND_W-1:0] QPOS_LIM = DIVIDEND_W'((1 << (QUOT_W - 1)) - 1);
    localparam logic [DIVIDEND_W-1:0] QNEG_LIM = DIVIDEND_W'(1 << (QUOT_W - 1));
    localparam logic signed [QUOT_W-1:0] QMAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic signed [QUOT_W-1:0] QMIN = {1'b1, {(QUOT_W-1){1'b0}}};

    // Saturating conversion of a quotient magnitude plus sign to QUOT_W bits.
    function automatic logic signed [QUOT_W-1:0] sat_quot(
        input logic [DIVIDEND_W-1:0] mag,
        input logic                  neg
    );
        if (!neg) begin
            sat_quot = (mag > QPOS_LIM) ? QMAX : $signed(mag[QUOT_W-1:0]);
        end else begin
            sat_quot = (mag > QNEG_LIM) ? QMIN : $signed(QUOT_W'(0) - mag[QUOT_W-1:0]);
        end
    endfunction

    function automatic logic quot_ovf(
        input logic [DIVIDEND_W-1:0] mag,
        input logic                  neg
    );
        quot_ovf = neg ? (mag > QNEG_LIM) : (mag > QPOS_LIM);
    endfunction

    function automatic logic signed [DIVISOR_W-1:0] apply_sign(
        input logic [DIVISOR_W-1:0] mag,
        input logic                 neg
    );
        apply_sign = neg ? $signed(DIVISOR_W'(0) - mag) : $signed(mag);
    endfunction

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    // Dividend magnitude; quotient bits shift in from the LSB as it drains.
    logic [DIVIDEND_W-1:0]      dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]       dvs_q, dvs_d;
    logic [DIVISOR_W:0]         pr_q, pr_d;
    logic                       s0_q, s0_d;
    logic                       s1_q, s1_d;
    logic                       zero_q, zero_d;
    logic signed [QUOT_W-1:0]   dout_q, dout_d;
    logic signed [DIVISOR_W-1:0] rem_q, rem_d;
    logic                       ovf_q, ovf_d;
    logic                       dbz_q, dbz_d;
    logic                       done_q, done_d;
    logic                       idle_q, idle_d;

    logic [DIVIDEND_W-1:0]      abs0;
    logic [DIVISOR_W-1:0]       abs1;
    logic [DIVISOR_W+1:0]       trial;
    logic [DIVISOR_W+1:0]       diff;
    logic                       qbit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        zero_d  = zero_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        idle_d  = idle_q;

        // Unsigned magnitudes: the most-negative values map to 2^(W-1) exactly.
        abs0 = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;
        abs1 = din1[DIVISOR_W-1]  ? (~din1 + 1'b1) : din1;

        // One extra bit above the partial remainder gives the borrow/sign.
        trial = {pr_q, dvd_q[DIVIDEND_W-1]};
        diff  = trial - {2'b00, dvs_q};
        qbit  = ~diff[DIVISOR_W+1];

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    dvd_d   = abs0;
                    dvs_d   = abs1;
                    s0_d    = din0[DIVIDEND_W-1];
                    s1_d    = din1[DIVISOR_W-1];
                    zero_d  = (din1 == '0);
                    pr_d    = '0;
                    cnt_d   = CNT_INIT;
                    idle_d  = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // A zero divisor still runs every step so latency is fixed.
                pr_d  = qbit ? diff[DIVISOR_W:0] : trial[DIVISOR_W:0];
                dvd_d = {dvd_q[DIVIDEND_W-2:0], qbit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (zero_q) begin
                    dout_d = s0_q ? QMIN : QMAX;
                    rem_d  = '0;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b1;
                end else begin
                    dout_d = sat_quot(dvd_q, s0_q ^ s1_q);
                    ovf_d  = quot_ovf(dvd_q, s0_q ^ s1_q);
                    rem_d  = apply_sign(pr_q[DIVISOR_W-1:0], s0_q);
                    dbz_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                idle_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                idle_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            zero_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            zero_q  <= zero_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
        end
    end

    assign ap_idle = idle_q;
    assign ap_done = done_q;
    assign dout    = dout_q;
    assign rem     = rem_q;
    assign ovf     = ovf_q;
    assign dbz     = dbz_q;

endmodule
